// File: rtl/dbus_sram_responder.sv
// ============================================================================
// Module : dbus_sram_responder
// Brief  : Data-bus slave backed by a 64-bit word array with programmable
//          response latency, sticky decode error and transaction counter.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dbus_sram_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        busy,
  output logic        decode_err,
  output logic [31:0] req_count,
  input  logic        cnt_preload_en,
  input  logic [31:0] cnt_preload_val
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [63:0] WIN_BYTES = 64'(DEPTH_WORDS) << 3;
  localparam logic [3:0]  WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [7:0]  strobe_q, strobe_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        decode_err_q, decode_err_d;
  logic [31:0] req_count_q, req_count_d;

  logic [63:0]      mem_array [DEPTH_WORDS];
  logic [63:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [63:0]      rd_word;
  logic             wr_en;
  logic             unused_size;

  // Size is latched with the request but lanes are selected by strobe only.
  assign unused_size = ^size_q;

  always_comb begin
    offset   = addr_q - BASE_ADDR;
    in_range = (addr_q >= BASE_ADDR) && (offset < WIN_BYTES);
    idx      = offset[IDX_W+2:3];
    rd_word  = in_range ? mem_array[idx] : 64'd0;
    wr_en    = (state_q == ST_RESP) && in_range && (strobe_q != 8'd0);
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    addr_d       = addr_q;
    size_d       = size_q;
    strobe_d     = strobe_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    decode_err_d = decode_err_q;
    req_count_d  = req_count_q;

    case (state_q)
      ST_IDLE: begin
        if (dreq_valid) begin
          addr_d   = dreq_addr;
          size_d   = dreq_size;
          strobe_d = dreq_strobe;
          wdata_d  = dreq_data;
          if (LATENCY > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d      = ST_IDLE;
        rdata_d      = rd_word;
        decode_err_d = decode_err_q | ~in_range;
        req_count_d  = req_count_q + 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (cnt_preload_en) begin
      req_count_d = cnt_preload_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 4'd0;
      addr_q       <= 64'd0;
      size_q       <= 3'd0;
      strobe_q     <= 8'd0;
      wdata_q      <= 64'd0;
      rdata_q      <= 64'd0;
      decode_err_q <= 1'b0;
      req_count_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      strobe_q     <= strobe_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      decode_err_q <= decode_err_d;
      req_count_q  <= req_count_d;
    end
  end

  // Array is deliberately left out of reset; a reset during RESP suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (strobe_q[b]) begin
          mem_array[idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign dresp_addr_ok = (state_q == ST_RESP);
  assign dresp_data_ok = (state_q == ST_RESP);
  assign dresp_data    = (state_q == ST_RESP) ? rd_word : rdata_q;
  assign busy          = (state_q != ST_IDLE);
  assign decode_err    = decode_err_q;
  assign req_count     = req_count_q;

endmodule

`default_nettype wire

// File: tb/tb_dbus_sram_responder.sv
// ============================================================================
// Module : tb_dbus_sram_responder
// Brief  : Scoreboard bench for dbus_sram_responder at LATENCY 2 and 0.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dbus_sram_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst2, valid0, valid2, pre_en;
  logic [63:0] addr, wdata;
  logic [2:0]  size;
  logic [7:0]  strb;
  logic [31:0] pre_val;

  logic        d0_aok, d0_dok, d0_busy, d0_derr;
  logic [63:0] d0_data;
  logic [31:0] d0_cnt;
  logic        d2_aok, d2_dok, d2_busy, d2_derr;
  logic [63:0] d2_data;
  logic [31:0] d2_cnt;

  dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst2), .dreq_valid(valid2), .dreq_addr(addr), .dreq_size(size),
    .dreq_strobe(strb), .dreq_data(wdata), .dresp_addr_ok(d2_aok), .dresp_data_ok(d2_dok),
    .dresp_data(d2_data), .busy(d2_busy), .decode_err(d2_derr), .req_count(d2_cnt),
    .cnt_preload_en(1'b0), .cnt_preload_val(32'd0)
  );

  dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst0), .dreq_valid(valid0), .dreq_addr(addr), .dreq_size(size),
    .dreq_strobe(strb), .dreq_data(wdata), .dresp_addr_ok(d0_aok), .dresp_data_ok(d0_dok),
    .dresp_data(d0_data), .busy(d0_busy), .decode_err(d0_derr), .req_count(d0_cnt),
    .cnt_preload_en(pre_en), .cnt_preload_val(pre_val)
  );

  typedef struct {
    logic [63:0] data;
    bit          care;
  } exp_t;

  exp_t        q0[$], q2[$];
  logic [63:0] m0[int], m2[int];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference behaviour: returns the expected response word and updates the model.
  function automatic exp_t predict(input bit sel, input logic [63:0] a,
                                   input logic [7:0] s, input logic [63:0] d);
    exp_t        e;
    bit          inr;
    int          idx;
    logic [63:0] w;
    inr    = (a >= BASE) && ((a - BASE) < (64'(DEPTH) * 64'd8));
    idx    = int'(((a - BASE) >> 3) & 64'(DEPTH - 1));
    e.data = 64'd0;
    e.care = 1'b1;
    if (inr) begin
      if (sel ? m2.exists(idx) : m0.exists(idx)) e.data = sel ? m2[idx] : m0[idx];
      else e.care = 1'b0;
      if (s != 8'd0) begin
        w = e.data;
        for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        if (!e.care) begin
          // Untouched lanes of a never-written word stay unknown; only full writes seed the model.
          if (s == 8'hFF) begin
            if (sel) m2[idx] = w; else m0[idx] = w;
          end
        end else begin
          if (sel) m2[idx] = w; else m0[idx] = w;
        end
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin : mon2
    exp_t e;
    if (d2_aok || d2_dok) begin
      chk("ok_pair2", d2_aok, d2_dok);
      if (q2.size() == 0) chk("unexpected_ok2", 1, 0);
      else begin
        e = q2.pop_front();
        if (e.care) chk("rdata2", d2_data, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (d0_aok || d0_dok) begin
      chk("ok_pair0", d0_aok, d0_dok);
      if (q0.size() == 0) chk("unexpected_ok0", 1, 0);
      else begin
        e = q0.pop_front();
        if (e.care) chk("rdata0", d0_data, e.data);
      end
    end
  end

  // One transaction; returns at the negedge inside the RESP cycle.
  task automatic txn(input bit sel, input logic [63:0] a, input logic [7:0] s,
                     input logic [63:0] d, input logic [2:0] sz);
    exp_t e;
    int   lat;
    bit   seen;
    e = predict(sel, a, s, d);
    if (sel) q2.push_back(e); else q0.push_back(e);
    @(negedge clk);
    addr = a; strb = s; wdata = d; size = sz;
    if (sel) valid2 = 1'b1; else valid0 = 1'b1;
    @(posedge clk);
    #1;
    valid2 = 1'b0; valid0 = 1'b0;
    addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    strb = 8'($urandom); size = 3'($urandom);
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (sel ? d2_dok : d0_dok) seen = 1'b1;
    end
    if (!seen) chk("timeout", 0, 1);
    else chk(sel ? "latency2" : "latency0", 64'(lat), sel ? 64'd3 : 64'd1);
  endtask

  initial begin
    exp_t e;
    int   n_ok;
    bit   gap_next;

    rst0 = 1'b1; rst2 = 1'b1; valid0 = 1'b0; valid2 = 1'b1; pre_en = 1'b0; pre_val = 32'd0;
    addr = BASE; wdata = 64'd0; strb = 8'd0; size = 3'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy2", d2_busy, 0);
    chk("rst_ok2", d2_dok, 0);
    chk("rst_data2", d2_data, 0);
    chk("rst_derr2", d2_derr, 0);
    chk("rst_cnt2", d2_cnt, 0);
    chk("rst_busy0", d0_busy, 0);
    valid2 = 1'b0; rst0 = 1'b0; rst2 = 1'b0;

    txn(1, BASE + 64'h10, 8'hFF, 64'h1122_3344_5566_7788, 3'd3);
    txn(1, BASE + 64'h10, 8'h00, 64'h0, 3'd3);
    @(negedge clk);
    chk("cnt_two", d2_cnt, 2);
    txn(1, BASE + 64'h10, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 3'd2);
    txn(1, BASE + 64'h10, 8'h00, 64'h0, 3'd3);
    chk("merge_word", d2_data, 64'h1122_3344_BBBB_BBBB);
    txn(1, BASE, 8'hFF, 64'h0123_4567_89AB_CDEF, 3'd3);

    for (int i = 0; i < 4; i++)
      txn(1, BASE + 64'h200 + 64'(8 * i), 8'hFF, {$urandom, $urandom}, 3'd3);
    for (int i = 0; i < 8; i++)
      txn(1, BASE + 64'h200 + 64'(8 * $urandom_range(0, 3)),
          ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom),
          {$urandom, $urandom}, 3'($urandom_range(0, 3)));

    txn(1, BASE + 64'(8 * (DEPTH - 1)), 8'hFF, 64'hFEED_FACE_0000_1111, 3'd3);
    txn(1, BASE + 64'(8 * (DEPTH - 1)), 8'h00, 64'h0, 3'd3);
    @(negedge clk);
    chk("derr_clean", d2_derr, 0);

    txn(1, 64'h7FFF_FFF8, 8'h00, 64'h0, 3'd3);
    chk("oor_rdata", d2_data, 0);
    @(negedge clk);
    chk("derr_set", d2_derr, 1);
    txn(1, BASE + 64'(8 * DEPTH), 8'hFF, 64'h5555_6666_7777_8888, 3'd3);
    txn(1, BASE, 8'h00, 64'h0, 3'd3);
    @(negedge clk);
    chk("derr_sticky", d2_derr, 1);

    // Valid held high across two transactions: one pulse each, IDLE gap between.
    e = predict(1, BASE + 64'h10, 8'h00, 64'h0); q2.push_back(e);
    e = predict(1, BASE + 64'h10, 8'h00, 64'h0); q2.push_back(e);
    @(negedge clk);
    addr = BASE + 64'h10; strb = 8'h00; valid2 = 1'b1;
    n_ok = 0; gap_next = 1'b0;
    for (int i = 0; i < 30 && n_ok < 2; i++) begin
      @(negedge clk);
      if (gap_next) begin
        chk("idle_gap", d2_busy, 0);
        gap_next = 1'b0;
      end
      if (d2_dok) begin
        n_ok++;
        gap_next = 1'b1;
      end
    end
    valid2 = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_pulses", 64'(n_ok), 2);

    // Reset in the second WAIT cycle of a write must abort it.
    @(negedge clk);
    addr = BASE; strb = 8'hFF; wdata = 64'hDEAD_BEEF_CAFE_F00D; valid2 = 1'b1;
    @(posedge clk);
    #1 valid2 = 1'b0;
    @(posedge clk);
    #1 rst2 = 1'b1; valid2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", d2_busy, 0);
    chk("abort_cnt", d2_cnt, 0);
    chk("abort_derr", d2_derr, 0);
    chk("abort_ok", d2_dok, 0);
    valid2 = 1'b0; rst2 = 1'b0;
    txn(1, BASE, 8'h00, 64'h0, 3'd3);
    chk("abort_keep", d2_data, 64'h0123_4567_89AB_CDEF);

    txn(0, BASE + 64'h100, 8'hFF, 64'hCAFE_0000_BEEF_0001, 3'd3);
    txn(0, BASE + 64'h100, 8'h00, 64'h0, 3'd3);
    chk("l0_rdata", d0_data, 64'hCAFE_0000_BEEF_0001);
    @(negedge clk);
    pre_en = 1'b1; pre_val = 32'hFFFF_FFFF;
    @(negedge clk);
    pre_en = 1'b0;
    chk("preload", d0_cnt, 32'hFFFF_FFFF);
    txn(0, BASE + 64'h100, 8'h00, 64'h0, 3'd3);
    @(negedge clk);
    chk("cnt_wrap", d0_cnt, 0);

    repeat (3) @(negedge clk);
    chk("drain2", 64'(q2.size()), 0);
    chk("drain0", 64'(q0.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
